// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding and clog2 helper for the serial arithmetic blocks
package arith_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: combinational one-bit adder cell (a, b, cin -> sum, cout)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder; start/a/b in, busy/done/sum/carry_out out
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] sha, shb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_n;
    logic [CW-1:0]    cnt;
    logic             cy, s, co;
    full_adder fa (.a(sha[0]), .b(shb[0]), .cin(cy), .sum(s), .cout(co));
    assign res_n = {s, res};
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sha       <= '0;
            shb       <= '0;
            res       <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    sha <= sha >> 1;
                    shb <= shb >> 1;
                    res <= res_n[WIDTH-1:1];
                    cy  <= co;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= res_n;
                        carry_out <= co;
                    end
                end
                default: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        sha   <= a;
                        shb   <= b;
                        cy    <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against arithmetic a+b
module tb_serial_adder;
    logic       clk;
    logic       rst8, start8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       rst4, start4, busy4, done4, co4;
    logic [3:0] a4, b4, sum4;
    int         n_cmp, n_bad;

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic kick8(input logic [7:0] a, input logic [7:0] b);
        a8 = a;
        b8 = b;
        start8 = 1;
        @(negedge clk);
        start8 = 0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic wait8(output int lat, output int bc);
        lat = 0;
        bc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst8 = 1; rst4 = 1; start8 = 0; start4 = 0;
        a8 = 0; b8 = 0; a4 = 0; b4 = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done8); end
        n_cmp++; if (sum8 !== 8'd0) begin n_bad++; $display("FAIL reset_sum got %0d want 0", sum8); end
        n_cmp++; if (co8 !== 1'b0) begin n_bad++; $display("FAIL reset_carry got %b want 0", co8); end
        rst8 = 0; rst4 = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        kick8(8'd3, 8'd5);
        wait8(lat, bc);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        n_cmp++; if ({co8, sum8} !== 9'd8) begin n_bad++; $display("FAIL basic_result got %0d want 8", {co8, sum8}); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy8); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done8); end
    endtask

    task automatic test_carry_hold;
        int lat, bc, held_bad;
        kick8(8'd255, 8'd1);
        wait8(lat, bc);
        n_cmp++; if ({co8, sum8} !== 9'h100) begin n_bad++; $display("FAIL carry_result got %0h want 100", {co8, sum8}); end
        repeat (3) @(negedge clk);
        kick8(8'd200, 8'd100);
        held_bad = 0;
        lat = 0;
        while (!done8 && lat < 40) begin
            if ({co8, sum8} !== 9'h100) held_bad++;
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL carry_hold got %0d changed cycles want 0", held_bad); end
        n_cmp++; if ({co8, sum8} !== 9'd300) begin n_bad++; $display("FAIL carry_second got %0d want 300", {co8, sum8}); end
    endtask

    task automatic test_ignore_busy;
        int pulses;
        logic [8:0] got;
        kick8(8'd10, 8'd20);
        @(negedge clk);
        a8 = 8'd99; b8 = 8'd99; start8 = 1;
        @(negedge clk);
        start8 = 0;
        pulses = 0;
        got = '1;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin pulses++; got = {co8, sum8}; end
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        n_cmp++; if (got !== 9'd30) begin n_bad++; $display("FAIL ignore_result got %0d want 30", got); end
    endtask

    task automatic test_abort;
        int lat, bc, pulses;
        kick8(8'd7, 8'd9);
        repeat (3) @(negedge clk);
        rst8 = 1;
        @(negedge clk);
        rst8 = 0;
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy8); end
        n_cmp++; if (sum8 !== 8'd0) begin n_bad++; $display("FAIL abort_sum got %0d want 0", sum8); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_done got %0d pulses want 0", pulses); end
        kick8(8'd1, 8'd1);
        wait8(lat, bc);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL abort_restart_latency got %0d want 8", lat); end
        n_cmp++; if ({co8, sum8} !== 9'd2) begin n_bad++; $display("FAIL abort_restart_result got %0d want 2", {co8, sum8}); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        a8 = 8'h0F; b8 = 8'hF1; start8 = 1;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80;
        wait8(lat, bc);
        n_cmp++; if ({co8, sum8} !== 9'h100) begin n_bad++; $display("FAIL b2b_first got %0h want 100", {co8, sum8}); end
        @(negedge clk);
        start8 = 0;
        wait8(lat, bc);
        n_cmp++; if (lat + 1 !== 9) begin n_bad++; $display("FAIL b2b_spacing got %0d want 9", lat + 1); end
        n_cmp++; if ({co8, sum8} !== 9'h100) begin n_bad++; $display("FAIL b2b_second got %0h want 100", {co8, sum8}); end
        @(negedge clk);
    endtask

    task automatic test_random8;
        int lat, bc;
        logic [7:0] ra, rb;
        logic [8:0] exp;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp = 9'(ra) + 9'(rb);
            kick8(ra, rb);
            wait8(lat, bc);
            n_cmp++;
            if (lat !== 8 || {co8, sum8} !== exp) begin
                n_bad++;
                $display("FAIL random8 a=%0d b=%0d got %0d lat %0d want %0d lat 8", ra, rb, {co8, sum8}, lat, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_exhaustive4;
        int lat;
        logic [4:0] exp;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp = 5'(i) + 5'(j);
                a4 = 4'(i); b4 = 4'(j); start4 = 1;
                @(negedge clk);
                start4 = 0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                lat = 0;
                while (!done4 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                n_cmp++;
                if (lat !== 4 || {co4, sum4} !== exp) begin
                    n_bad++;
                    $display("FAIL exhaustive4 a=%0d b=%0d got %0d lat %0d want %0d lat 4", i, j, {co4, sum4}, lat, exp);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_carry_hold;
        test_ignore_busy;
        test_abort;
        test_back_to_back;
        test_random8;
        test_exhaustive4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
